// File: rtl/can_tdc_pkg.sv
// Shared constants and types for the CAN transmit / TDC front-end blocks.
package can_tdc_pkg;

  // Bus levels on the CAN logic line.
  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

  // Five equal bits force a complement stuff bit.
  localparam int STUFF_RUN = 5;
  // End-of-frame plus inter-frame space, in bit times.
  localparam int EOF_BITS  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STUFF = 2'd2,
    EOF   = 2'd3
  } tx_state_e;

  // Level of the stuff bit that follows a run of 'last'.
  function automatic logic stuff_level(input logic last);
    return (last == RECESSIVE) ? DOMINANT : RECESSIVE;
  endfunction

endpackage

// File: rtl/can_bit_timer.sv
// Bit-time tick counter: counts 0..BIT_TICKS-1 and flags the last tick of
// each bit. Also used by the receive-side sampler.
module can_bit_timer #(
  parameter int BIT_TICKS = 50
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_TICKS - 1);

  logic [CW-1:0] cnt;

  if (BIT_TICKS < 2 || BIT_TICKS > 65535) begin : g_bad_ticks
    $error("can_bit_timer: BIT_TICKS out of range 2..65535");
  end

  // Free-running modulo-BIT_TICKS count, held at zero while cleared.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                     cnt <= '0;
    else if (clear || cnt == LAST) cnt <= '0;
    else                          cnt <= cnt + CW'(1);
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/can_frame_tx.sv
// CAN bit-stream transmitter: shifts out a raw frame MSB first, inserts
// stuff bits after five equal levels, then holds recessive for EOF + IFS.
module can_frame_tx
  import can_tdc_pkg::*;
#(
  parameter int BIT_TICKS = 50,
  parameter int FRAME_W   = 64,
  parameter int LEN_W     = 7
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               LOAD,
  input  logic [FRAME_W-1:0] FRAME,
  input  logic [LEN_W-1:0]   LEN,
  output logic               READY,
  output logic               BUSY,
  output logic               CAN_TX,
  output logic               EDGE,
  output logic               STUFF_BIT,
  output logic               DONE
);

  localparam int EC_W = $clog2(EOF_BITS);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(FRAME_W);
  localparam logic [2:0]       RUN_MAX  = 3'(STUFF_RUN);
  localparam logic [EC_W-1:0]  EOF_LAST = EC_W'(EOF_BITS - 1);

  if ((2 ** LEN_W) <= FRAME_W) begin : g_bad_len_w
    $error("can_frame_tx: LEN_W too narrow for FRAME_W");
  end

  tx_state_e          state, state_n;
  logic               first, first_n;   // accepted, first bit not yet driven
  logic [FRAME_W-1:0] sh, sh_n;         // payload, next bit at the MSB
  logic [LEN_W-1:0]   len_q, len_n;
  logic [LEN_W-1:0]   idx, idx_n;       // payload bits already driven
  logic [2:0]         run, run_n;       // equal-level run, 1..5
  logic [EC_W-1:0]    eof_cnt, eof_n;
  logic               tx_n;
  logic               bit_end;
  logic               clear;

  // Hold the bit timer at zero until the first bit goes out, so every bit
  // (including the first) lasts exactly BIT_TICKS cycles.
  assign clear = (state == IDLE) || first;

  can_bit_timer #(.BIT_TICKS(BIT_TICKS)) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (clear),
    .bit_end (bit_end)
  );

  // Next-state and next-bit selection; a new bit is chosen on the first
  // step after acceptance and at every bit boundary thereafter.
  always_comb begin
    state_n = state;
    first_n = first;
    sh_n    = sh;
    len_n   = len_q;
    idx_n   = idx;
    run_n   = run;
    eof_n   = eof_cnt;
    tx_n    = CAN_TX;
    case (state)
      IDLE: begin
        tx_n = RECESSIVE;
        if (LOAD && (LEN != '0)) begin
          state_n = DATA;
          first_n = 1'b1;
          sh_n    = FRAME;
          len_n   = (LEN > LEN_MAX) ? LEN_MAX : LEN;
          idx_n   = '0;
        end
      end
      DATA, STUFF: begin
        if (first) begin
          first_n = 1'b0;
          tx_n    = sh[FRAME_W-1];
          sh_n    = sh << 1;
          idx_n   = LEN_W'(1);
          run_n   = 3'd1;
        end else if (bit_end) begin
          if (run == RUN_MAX) begin
            // Stuff check runs before the end-of-payload check so a run
            // finishing on the last payload bit still gets its stuff bit.
            state_n = STUFF;
            tx_n    = stuff_level(CAN_TX);
            run_n   = 3'd1;
          end else if (idx < len_q) begin
            state_n = DATA;
            tx_n    = sh[FRAME_W-1];
            sh_n    = sh << 1;
            idx_n   = idx + LEN_W'(1);
            run_n   = (sh[FRAME_W-1] == CAN_TX) ? run + 3'd1 : 3'd1;
          end else begin
            state_n = EOF;
            tx_n    = RECESSIVE;
            eof_n   = '0;
          end
        end
      end
      EOF: begin
        tx_n = RECESSIVE;
        if (bit_end) begin
          if (eof_cnt == EOF_LAST) state_n = IDLE;
          else                     eof_n   = eof_cnt + EC_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM, shift register and counters.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      first   <= 1'b0;
      sh      <= '0;
      len_q   <= '0;
      idx     <= '0;
      run     <= 3'd1;
      eof_cnt <= '0;
    end else begin
      state   <= state_n;
      first   <= first_n;
      sh      <= sh_n;
      len_q   <= len_n;
      idx     <= idx_n;
      run     <= run_n;
      eof_cnt <= eof_n;
    end
  end

  // Bus line and its transition marker, registered together.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      CAN_TX <= RECESSIVE;
      EDGE   <= 1'b0;
    end else begin
      CAN_TX <= tx_n;
      EDGE   <= (tx_n != CAN_TX);
    end
  end

  assign READY     = (state == IDLE);
  assign BUSY      = ~READY;
  assign STUFF_BIT = (state == STUFF);
  assign DONE      = (state == EOF) && bit_end && (eof_cnt == EOF_LAST);

endmodule

// File: tb/tb_can_frame_tx.sv
// Bench for can_frame_tx: directed vector table, hand sequences for reset
// and protocol corners, and random frames against a bit-list model.
module tb_can_frame_tx;

  localparam int BT = 4;
  localparam int FW = 64;
  localparam int LW = 7;

  logic          CLK = 1'b0;
  logic          RST, LOAD;
  logic [FW-1:0] FRAME;
  logic [LW-1:0] LEN;
  logic          READY, BUSY, CAN_TX, EDGE, STUFF_BIT, DONE;

  int total = 0;
  int bad   = 0;

  can_frame_tx #(.BIT_TICKS(BT), .FRAME_W(FW), .LEN_W(LW)) dut (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .FRAME(FRAME), .LEN(LEN),
    .READY(READY), .BUSY(BUSY), .CAN_TX(CAN_TX), .EDGE(EDGE),
    .STUFF_BIT(STUFF_BIT), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected bit list for a frame: payload, stuff bits, then EOF + IFS.
  logic exp_bits[$];
  logic exp_stf[$];

  task automatic build_model(input logic [FW-1:0] f, input int len);
    int n, runlen, prev;
    logic b;
    exp_bits.delete();
    exp_stf.delete();
    n = (len > FW) ? FW : len;
    runlen = 0;
    prev = -1;
    for (int i = 0; i < n; i++) begin
      b = f[FW-1-i];
      exp_bits.push_back(b);
      exp_stf.push_back(1'b0);
      runlen = (int'(b) == prev) ? runlen + 1 : 1;
      prev = int'(b);
      if (runlen == 5) begin
        exp_bits.push_back(~b);
        exp_stf.push_back(1'b1);
        prev = int'(~b);
        runlen = 1;
      end
    end
    for (int i = 0; i < 10; i++) begin
      exp_bits.push_back(1'b1);
      exp_stf.push_back(1'b0);
    end
  endtask

  // Send one frame and compare every cycle against the model. 'poke' is a
  // cycle at which a second LOAD is attempted (-1 for none).
  task automatic run_frame(input string tag, input logic [FW-1:0] f, input int len,
                           input int poke, output int done_cyc, output int edges,
                           output int stuffc);
    int ncyc, wave_bad, edge_bad, stf_bad, busy_bad, done_cnt;
    logic prev_tx, etx, estf, eedge;
    build_model(f, len);
    ncyc = exp_bits.size() * BT;
    wave_bad = 0; edge_bad = 0; stf_bad = 0; busy_bad = 0; done_cnt = 0;
    done_cyc = -1; edges = 0; stuffc = 0;
    chk({tag, " ready_before"}, 32'(READY), 32'd1);
    @(negedge CLK);
    LOAD = 1'b1; FRAME = f; LEN = LW'(len);
    @(posedge CLK); #1;
    LOAD = 1'b0; FRAME = {$urandom, $urandom};
    // Accepted, first bit not yet on the line.
    if (CAN_TX !== 1'b1) wave_bad++;
    if (EDGE !== 1'b0) edge_bad++;
    if (STUFF_BIT !== 1'b0) stf_bad++;
    if (BUSY !== 1'b1 || READY !== 1'b0) busy_bad++;
    if (DONE === 1'b1) done_cnt++;
    prev_tx = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge CLK); #1;
      LOAD = 1'b0;
      etx   = exp_bits[(c-1)/BT];
      estf  = exp_stf[(c-1)/BT];
      eedge = (etx != prev_tx);
      if (CAN_TX !== etx) wave_bad++;
      if (EDGE !== eedge) edge_bad++;
      if (STUFF_BIT !== estf) stf_bad++;
      if (BUSY !== 1'b1 || READY !== 1'b0) busy_bad++;
      if (DONE === 1'b1) begin done_cnt++; done_cyc = c; end
      if (EDGE === 1'b1) edges++;
      if (STUFF_BIT === 1'b1) stuffc++;
      prev_tx = etx;
      if (c == poke) begin
        LOAD = 1'b1; FRAME = {$urandom, $urandom}; LEN = LW'($urandom_range(1, 64));
      end
    end
    @(posedge CLK); #1;
    LOAD = 1'b0;
    chk({tag, " wave"}, 32'(wave_bad), 32'd0);
    chk({tag, " edge"}, 32'(edge_bad), 32'd0);
    chk({tag, " stuff"}, 32'(stf_bad), 32'd0);
    chk({tag, " busy"}, 32'(busy_bad), 32'd0);
    chk({tag, " done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, " done_model_cycle"}, 32'(done_cyc), 32'(ncyc));
    chk({tag, " ready_after"}, 32'(READY), 32'd1);
    chk({tag, " done_after"}, 32'(DONE), 32'd0);
  endtask

  typedef struct {
    string      name;
    logic [FW-1:0] f;
    int         len;
    int         poke;
    int         exp_done;
    int         exp_edges;
    int         exp_stuff;   // cycles with STUFF_BIT high
  } vec_t;

  vec_t tbl[6];

  initial begin
    int dc, ed, sc, cnt_tx, cnt_ev, cnt_rdy;
    logic [FW-1:0] rf;

    tbl[0] = '{"alt8",   64'h55AB_CDEF_0123_4567,   8, 10,  72,  8, 0};
    tbl[1] = '{"zero8",  64'h00F0_F0F0_F0F0_F0F0,   8, -1,  76,  4, 4};
    tbl[2] = '{"trail6", 64'h7FFF_0000_FFFF_0000,   6, -1,  68,  4, 4};
    tbl[3] = '{"sat100", 64'h5555_5555_5555_5555, 100, -1, 296, 64, 0};
    tbl[4] = '{"ones8",  64'hFF00_1234_0000_0000,   8, -1,  76,  2, 4};
    tbl[5] = '{"zero10", 64'h003F_FFFF_FFFF_FFFF,  10, -1,  88,  4, 8};

    RST = 1'b0; LOAD = 1'b0; FRAME = '0; LEN = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst tx", 32'(CAN_TX), 32'd1);
    chk("rst ready", 32'(READY), 32'd1);
    chk("rst busy", 32'(BUSY), 32'd0);
    chk("rst pulses", 32'({EDGE, STUFF_BIT, DONE}), 32'd0);

    // Idle after reset release: line stays recessive, no pulses.
    @(negedge CLK); RST = 1'b1;
    cnt_tx = 0; cnt_ev = 0; cnt_rdy = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge CLK); #1;
      if (CAN_TX !== 1'b1) cnt_tx++;
      if (EDGE !== 1'b0 || DONE !== 1'b0 || STUFF_BIT !== 1'b0) cnt_ev++;
      if (READY !== 1'b1 || BUSY !== 1'b0) cnt_rdy++;
    end
    chk("idle tx", 32'(cnt_tx), 32'd0);
    chk("idle pulses", 32'(cnt_ev), 32'd0);
    chk("idle ready", 32'(cnt_rdy), 32'd0);

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].name, tbl[i].f, tbl[i].len, tbl[i].poke, dc, ed, sc);
      chk({tbl[i].name, " done_cycle"}, 32'(dc), 32'(tbl[i].exp_done));
      chk({tbl[i].name, " edge_count"}, 32'(ed), 32'(tbl[i].exp_edges));
      chk({tbl[i].name, " stuff_cycles"}, 32'(sc), 32'(tbl[i].exp_stuff));
      repeat (2) @(posedge CLK);
    end

    // LEN=0 request is ignored.
    @(negedge CLK); LOAD = 1'b1; FRAME = '0; LEN = '0;
    @(posedge CLK); #1; LOAD = 1'b0;
    chk("len0 ready", 32'(READY), 32'd1);
    cnt_tx = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK); #1;
      if (CAN_TX !== 1'b1 || EDGE !== 1'b0 || READY !== 1'b1) cnt_tx++;
    end
    chk("len0 quiet", 32'(cnt_tx), 32'd0);

    // Reset during a dominant data bit, then a clean restart.
    @(negedge CLK); LOAD = 1'b1; FRAME = '0; LEN = LW'(8);
    @(posedge CLK); #1; LOAD = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    chk("mid dominant", 32'(CAN_TX), 32'd0);
    RST = 1'b0;
    #1;
    chk("mid rst tx", 32'(CAN_TX), 32'd1);
    chk("mid rst ready", 32'(READY), 32'd1);
    cnt_ev = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      if (DONE !== 1'b0 || CAN_TX !== 1'b1) cnt_ev++;
    end
    @(negedge CLK); RST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      if (DONE !== 1'b0 || EDGE !== 1'b0 || CAN_TX !== 1'b1) cnt_ev++;
    end
    chk("mid rst quiet", 32'(cnt_ev), 32'd0);
    run_frame("post_rst", tbl[1].f, 8, -1, dc, ed, sc);
    chk("post_rst done_cycle", 32'(dc), 32'd76);
    chk("post_rst stuff_cycles", 32'(sc), 32'd4);

    // Random frames, biased toward long runs to exercise stuffing.
    for (int i = 0; i < 20; i++) begin
      int k, len, poke;
      k = $urandom_range(0, 2);
      rf = {$urandom, $urandom};
      if (k == 1) rf = rf & {$urandom, $urandom} & {$urandom, $urandom};
      if (k == 2) rf = rf | {$urandom, $urandom} | {$urandom, $urandom};
      len  = $urandom_range(1, 70);
      poke = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : -1;
      run_frame("rnd", rf, len, poke, dc, ed, sc);
      repeat ($urandom_range(0, 3)) @(posedge CLK);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
